// File: rtl/liang_pkg.sv
// rtl/liang_pkg.sv - shared widths, types and state encodings for the memory arbiter
// Purpose: holds the bus widths, the arbiter FSM state and owner enums, and the
//          packed memory-request record latched by mem_arbiter.
// Ports:   none (package).
package liang_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef logic [ADDR_WIDTH-1:0] paddr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic   wen;
    paddr_t addr;
    data_t  wdata;
    strb_t  wstrb;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:   req[1:0] - request vector (bit 0 = IFU, bit 1 = LSU)
//          last     - requester granted last time (0 = IFU, 1 = LSU)
//          gnt[1:0] - one-hot grant, all zero when nothing requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter onto a single-outstanding memory port
// Purpose: grants one of the IFU (read-only) and LSU requesters, forwards the
//          latched request to memory and routes the single response back to
//          the owner. At most one memory transaction is in flight.
// Ports:   clock, reset                       - clock, async active-high reset
//          ifu_req_valid/ready/addr           - IFU fetch request
//          ifu_rsp_valid                      - IFU response pulse
//          lsu_req_valid/ready/wen/addr/wdata/wstrb - LSU load/store request
//          lsu_rsp_valid                      - LSU response pulse
//          rsp_rdata                          - shared response data
//          mem_req_valid/ready/wen/addr/wdata/wstrb - memory request channel
//          mem_rsp_valid/rdata                - memory response channel
module mem_arbiter
  import liang_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_rsp_valid,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_req_wstrb,
  output logic                  lsu_rsp_valid,

  output logic [DATA_WIDTH-1:0] rsp_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [STRB_WIDTH-1:0] mem_req_wstrb,

  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e last_grant_q, last_grant_d;
  arb_owner_e owner_q, owner_d;
  mem_req_t   req_q, req_d;
  logic       mem_req_valid_q, mem_req_valid_d;
  data_t      rdata_q, rdata_d;

  logic [1:0] gnt;
  logic       grant_en;
  logic       rsp_fire;
  mem_req_t   ifu_req;
  mem_req_t   lsu_req;

  rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_grant_q == OWNER_LSU),
    .gnt  (gnt)
  );

  // Ready is combinational off the idle state, so it must be masked while
  // reset is held: the state register already reads ARB_IDLE during reset.
  assign grant_en      = !reset && (state_q == ARB_IDLE);
  assign ifu_req_ready = grant_en && gnt[0];
  assign lsu_req_ready = grant_en && gnt[1];

  // A memory response only counts while waiting for one; anything else is
  // treated as noise.
  assign rsp_fire      = !reset && (state_q == ARB_WAIT) && mem_rsp_valid;
  assign ifu_rsp_valid = rsp_fire && (owner_q == OWNER_IFU);
  assign lsu_rsp_valid = rsp_fire && (owner_q == OWNER_LSU);
  assign rsp_rdata     = rsp_fire ? mem_rsp_rdata : rdata_q;

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wen   = req_q.wen;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wstrb = req_q.wstrb;

  // Fetches are always reads with no byte enables.
  always_comb begin
    ifu_req       = '0;
    ifu_req.addr  = ifu_req_addr;
    lsu_req.wen   = lsu_req_wen;
    lsu_req.addr  = lsu_req_addr;
    lsu_req.wdata = lsu_req_wdata;
    lsu_req.wstrb = lsu_req_wstrb;
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    req_d           = req_q;
    mem_req_valid_d = mem_req_valid_q;
    rdata_d         = rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d         = gnt[1] ? OWNER_LSU : OWNER_IFU;
          last_grant_d    = gnt[1] ? OWNER_LSU : OWNER_IFU;
          req_d           = gnt[1] ? lsu_req : ifu_req;
          mem_req_valid_d = 1'b1;
          state_d         = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_rdata;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        mem_req_valid_d = 1'b0;
        state_d         = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ARB_IDLE;
      last_grant_q    <= OWNER_IFU;
      owner_q         <= OWNER_IFU;
      req_q           <= '0;
      mem_req_valid_q <= 1'b0;
      rdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      req_q           <= req_d;
      mem_req_valid_q <= mem_req_valid_d;
      rdata_q         <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wstrb (lsu_req_wstrb),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wen   (mem_req_wen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=0x%08h exp=0x%08h", tag, $time, got, exp);
    end
  endtask

  // Transaction-level model: is a transaction outstanding, has memory taken
  // it, who owns it, who was granted last, and what was latched.
  bit          m_busy, m_acc, m_owner_lsu, m_last_lsu;
  bit          m_wen;
  bit [31:0]   m_addr, m_wdata;
  bit [3:0]    m_wstrb;
  bit          m_wdata_known;
  bit [31:0]   m_rdata;
  bit          m_rdata_known;
  bit          g_ifu, g_lsu;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_owner_lsu = 0; m_last_lsu = 0;
    m_wen = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_wdata_known = 1;
    m_rdata_known = 0;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0;
    lsu_req_wdata = 0; lsu_req_wstrb = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
  endtask

  // Called just after a falling edge with inputs already driven; checks the
  // outputs, advances the model, and returns after the next falling edge.
  task automatic cycle();
    bit e_ir, e_lr, e_mv, resp;
    #1;
    if (reset) model_reset();
    e_ir = 0; e_lr = 0;
    if (!reset && !m_busy) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (m_last_lsu) e_ir = 1; else e_lr = 1;
      end else begin
        e_ir = ifu_req_valid;
        e_lr = lsu_req_valid;
      end
    end
    e_mv = !reset && m_busy && !m_acc;
    resp = !reset && m_busy && m_acc && mem_rsp_valid;

    chk("ifu_req_ready", 32'(ifu_req_ready), 32'(e_ir));
    chk("lsu_req_ready", 32'(lsu_req_ready), 32'(e_lr));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
    chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(resp && !m_owner_lsu));
    chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(resp && m_owner_lsu));
    chk("mem_req_wen",   32'(mem_req_wen),   32'(m_wen));
    chk("mem_req_addr",  mem_req_addr,       m_addr);
    chk("mem_req_wstrb", 32'(mem_req_wstrb), 32'(m_wstrb));
    if (m_wdata_known) chk("mem_req_wdata", mem_req_wdata, m_wdata);
    if (resp) chk("rsp_rdata_live", rsp_rdata, mem_rsp_rdata);
    else if (m_rdata_known) chk("rsp_rdata_hold", rsp_rdata, m_rdata);

    g_ifu = e_ir; g_lsu = e_lr;
    if (!reset) begin
      if (resp) begin
        m_busy = 0; m_rdata = mem_rsp_rdata; m_rdata_known = 1;
      end else if (m_busy && !m_acc && mem_req_ready) begin
        m_acc = 1;
      end
      if (e_ir) begin
        m_busy = 1; m_acc = 0; m_owner_lsu = 0; m_last_lsu = 0;
        m_wen = 0; m_addr = ifu_req_addr; m_wstrb = 0; m_wdata_known = 0;
      end else if (e_lr) begin
        m_busy = 1; m_acc = 0; m_owner_lsu = 1; m_last_lsu = 1;
        m_wen = lsu_req_wen; m_addr = lsu_req_addr; m_wstrb = lsu_req_wstrb;
        m_wdata = lsu_req_wdata; m_wdata_known = 1;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    @(negedge clock);
    ifu_req_valid = 1; lsu_req_valid = 1;
    cycle();                      // reset state: nothing ready while reset high
    idle_inputs();
    reset = 0;
    cycle();

    // IFU fetch, memory ready at once, response one cycle later
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    cycle();
    chk("ifu_grant_seen", 32'(g_ifu), 32'd1);
    ifu_req_valid = 0; mem_req_ready = 1;
    cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0413;
    cycle();
    idle_inputs();
    cycle();
    chk("rdata_after_fetch", rsp_rdata, 32'h0000_0413);

    // Tie after reset: LSU first, then IFU with both still requesting
    reset = 1; cycle(); reset = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 0;
    cycle();
    chk("tie1_lsu", 32'(g_lsu), 32'd1);
    mem_req_ready = 1; cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_2222; cycle();
    mem_rsp_valid = 0;
    cycle();
    chk("tie2_ifu", 32'(g_ifu), 32'd1);
    idle_inputs();
    mem_req_ready = 1; cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h3333_4444; cycle();
    idle_inputs(); cycle();

    // LSU store held off by memory for three cycles
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF;
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("store_addr_stable", mem_req_addr, 32'h8000_0100);
      chk("store_data_stable", mem_req_wdata, 32'hDEAD_BEEF);
    end
    mem_req_ready = 1; cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0; cycle();
    idle_inputs(); cycle();

    // Spurious responses in idle and while the request is pending
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_0001; cycle(); cycle();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010; cycle();
    ifu_req_valid = 0; mem_rsp_rdata = 32'hBAD0_0002; cycle(); cycle();
    mem_rsp_valid = 0; mem_req_ready = 1; cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h5555_6666; cycle();
    idle_inputs(); cycle();

    // Reset while waiting for the response, then a late response
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020; cycle();
    ifu_req_valid = 0; mem_req_ready = 1; cycle();
    mem_req_ready = 0; reset = 1; cycle();
    reset = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h7777_8888; cycle();
    mem_rsp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0024; cycle();
    chk("post_reset_grant", 32'(g_ifu), 32'd1);
    ifu_req_valid = 0; mem_req_ready = 1; cycle();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h9999_AAAA; cycle();
    idle_inputs(); cycle();

    // Randomised traffic: requesters hold a request until granted
    for (int n = 0; n < 3000; n++) begin
      if (g_ifu) ifu_req_valid = 0;
      if (g_lsu) lsu_req_valid = 0;
      if (!ifu_req_valid && ($urandom_range(0, 2) == 0)) begin
        ifu_req_valid = 1; ifu_req_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!lsu_req_valid && ($urandom_range(0, 2) == 0)) begin
        lsu_req_valid = 1; lsu_req_wen = 1'($urandom());
        lsu_req_addr = $urandom(); lsu_req_wdata = $urandom();
        lsu_req_wstrb = 4'($urandom());
      end
      mem_req_ready = ($urandom_range(0, 1) == 1);
      mem_rsp_valid = ($urandom_range(0, 4) < 2);
      mem_rsp_rdata = $urandom();
      reset = ($urandom_range(0, 299) == 0);
      if (reset) begin
        ifu_req_valid = 0; lsu_req_valid = 0;
      end
      cycle();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; widths SHALL come from liang_pkg (ADDR_WIDTH=32, DATA_WIDTH=32, STRB_WIDTH=4).
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid  in  1  IFU read request pending.
REQ-005 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-006 ifu_req_addr  in  32  IFU fetch address (paddr_t).
REQ-007 ifu_rsp_valid  out  1  one-cycle pulse; IFU read data on rsp_rdata.
REQ-008 lsu_req_valid  in  1  LSU request pending.
REQ-009 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-010 lsu_req_wen  in  1  1=store, 0=load.
REQ-011 lsu_req_addr  in  32  LSU address.
REQ-012 lsu_req_wdata  in  32  store data.
REQ-013 lsu_req_wstrb  in  4  store byte strobes.
REQ-014 lsu_rsp_valid  out  1  one-cycle pulse; load data or store completion.
REQ-015 rsp_rdata  out  32  response data, shared by both requesters.
REQ-016 mem_req_valid  out  1  request to memory.
REQ-017 mem_req_ready  in  1  memory accepts request.
REQ-018 mem_req_wen / mem_req_addr / mem_req_wdata / mem_req_wstrb  out  1/32/32/4  latched request fields.
REQ-019 mem_rsp_valid  in  1  memory response; always accepted, no back-pressure.
REQ-020 mem_rsp_rdata  in  32  memory read data.

Function
REQ-021 FSM states: ARB_IDLE, ARB_REQ, ARB_WAIT; at most one outstanding memory transaction.
REQ-022 ARB_IDLE: if any req_valid, grant exactly one requester, assert only its req_ready (combinational), latch its fields and owner, then go to ARB_REQ.
REQ-023 Tie (both valid in ARB_IDLE): grant the requester NOT granted last (round-robin); last_grant resets to IFU, so LSU wins the first tie.
REQ-024 Single requester valid: grant it regardless of last_grant; last_grant updates on every grant.
REQ-025 IFU grant: latch mem_req_wen=0 and mem_req_wstrb=0.
REQ-026 ARB_REQ: mem_req_valid=1, latched fields held stable; on mem_req_ready go to ARB_WAIT.
REQ-027 ARB_WAIT: on mem_rsp_valid, pulse the owner's rsp_valid for that same cycle, drive rsp_rdata=mem_rsp_rdata, then go to ARB_IDLE.
REQ-028 Outside ARB_WAIT, mem_rsp_valid SHALL be ignored: no rsp_valid pulse, no state change.
REQ-029 req_ready SHALL be 0 in ARB_REQ and ARB_WAIT; a new grant occurs no earlier than the cycle after a response.
REQ-030 Minimum latency: accept in cycle N, mem_req_valid in N+1, response pulse in N+2 at the earliest.
REQ-031 When no response is being driven, rsp_rdata SHALL hold its last value; neither rsp_valid is asserted.

Reset
REQ-032 reset SHALL force state=ARB_IDLE, last_grant=IFU, and latched fields=0; all valid and ready outputs SHALL be 0 while reset is high.
REQ-033 Reset asserted mid-transaction SHALL abandon it; a late mem_rsp_valid after reset SHALL be ignored per REQ-028.

Structure
REQ-034 liang_pkg SHALL hold arb_state_e, arb_owner_e {OWNER_IFU, OWNER_LSU}, and the packed struct mem_req_t {wen, addr, wdata, wstrb}.
REQ-035 Tie-break logic SHALL live in a sub-module rr_arb2 (2-way round-robin picker, inputs req[1:0] and last, output gnt[1:0]).

Verification
REQ-036 IFU only, addr=0x8000_0000; mem_req_ready=1; rsp 0x0000_0413 one cycle later -> ifu_rsp_valid pulse carrying 0x0000_0413, total latency 2 cycles.
REQ-037 Both valid from reset -> LSU granted first; on the next idle cycle, with both still valid -> IFU granted.
REQ-038 LSU store addr=0x8000_0100, wdata=0xDEAD_BEEF, wstrb=0xF; mem_req_ready low for 3 cycles -> fields stable all 3 cycles, lsu_rsp_valid on mem_rsp_valid.
REQ-039 Spurious mem_rsp_valid in ARB_IDLE and ARB_REQ -> no rsp_valid pulse, no state change.
REQ-040 Reset asserted in ARB_WAIT, then a late mem_rsp_valid -> no response pulse; state ARB_IDLE; next IFU request served normally.
